// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 capture receiver.
package hub75_pkg;

   localparam int unsigned COLS      = 64;
   localparam int unsigned SCAN_ROWS = 32;
   localparam int unsigned COL_W     = 6;
   localparam int unsigned ROW_W     = 5;
   localparam int unsigned FB_ADDR_W = 12;

   typedef enum logic [1:0] {
      StShift,
      StDrainTop,
      StDrainBot
   } cap_state_e;

   typedef struct packed {
      logic [2:0] rgb0;
      logic [2:0] rgb1;
   } line_ent_t;

endpackage

// File: rtl/hub75_sync_edge.sv
// Multi-stage synchronizer with per-bit rising-edge detect on the final stage.
module hub75_sync_edge #(
   parameter int unsigned    WIDTH     = 1,
   parameter int unsigned    STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(STAGES); i++) stage_q[i] <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < int'(STAGES); i++) stage_q[i] <= stage_q[i-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign q    = stage_q[STAGES-1];
   assign rise = q & ~prev_q;

endmodule

// File: rtl/hub75_capture_rx.sv
// HUB75 bus capture: rebuilds shifted lines and drains them into a 64x64 frame store.
// Optional HUB75_OE_CHECK_EN adds the sticky err_oe output.
module hub75_capture_rx
   import hub75_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hub_clk,
   input  logic                 hub_lat,
   input  logic                 hub_oe,
   input  logic [2:0]           hub_rgb0,
   input  logic [2:0]           hub_rgb1,
   input  logic [ROW_W-1:0]     hub_addr,
   output logic                 wr_en,
   output logic [FB_ADDR_W-1:0] wr_addr,
   output logic [2:0]           wr_data,
   output logic                 line_done,
   output logic                 frame_done,
   output logic                 err_short,
`ifdef HUB75_OE_CHECK_EN
   output logic                 err_oe,
`endif
   output logic                 err_overrun
);

   localparam logic [COL_W:0]   ColsFull = (COL_W+1)'(COLS);
   localparam logic [COL_W-1:0] LastIdx  = COL_W'(COLS - 1);
   localparam logic [ROW_W-1:0] LastRow  = ROW_W'(SCAN_ROWS - 1);

   logic        hclk_q, hclk_rise, hlat_q, hlat_rise;
   logic [11:0] data_q, data_rise;
   logic        oe_s;
   logic [ROW_W-1:0] addr_s;
   logic [2:0]  rgb0_s, rgb1_s;

   hub75_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clk (
      .clk  (clk),
      .rst  (rst),
      .d    (hub_clk),
      .q    (hclk_q),
      .rise (hclk_rise)
   );

   hub75_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_lat (
      .clk  (clk),
      .rst  (rst),
      .d    (hub_lat),
      .q    (hlat_q),
      .rise (hlat_rise)
   );

   // OE resets high (panel dark) so the pipeline fill never looks like a lit panel.
   hub75_sync_edge #(.WIDTH(12), .STAGES(SYNC_STAGES), .RESET_VAL(12'h800)) u_sync_data (
      .clk  (clk),
      .rst  (rst),
      .d    ({hub_oe, hub_addr, hub_rgb1, hub_rgb0}),
      .q    (data_q),
      .rise (data_rise)
   );

   assign oe_s   = data_q[11];
   assign addr_s = data_q[10:6];
   assign rgb1_s = data_q[5:3];
   assign rgb0_s = data_q[2:0];

   cap_state_e       state_q, state_d;
   logic [COL_W:0]   col_q, col_d;
   logic [COL_W-1:0] drain_q, drain_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             short_q, short_d, overrun_q, overrun_d;
   logic             line_done_q, line_done_d, frame_done_q, frame_done_d;
   logic             buf_we;
   line_ent_t        line_buf [COLS];
   line_ent_t        rd_ent;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      drain_d      = drain_q;
      row_d        = row_q;
      short_d      = short_q;
      overrun_d    = overrun_q;
      line_done_d  = 1'b0;
      frame_done_d = 1'b0;
      buf_we       = 1'b0;

      // Shift is handled before the latch so a same-cycle pixel joins the committed line.
      if (hclk_rise) begin
         if (col_q == ColsFull) begin
            overrun_d = 1'b1;
         end else begin
            buf_we = (state_q == StShift) || (col_q[COL_W-1:0] <= drain_q);
            col_d  = col_q + 1'b1;
         end
      end

      case (state_q)
         StShift: begin
            if (hlat_rise) begin
               row_d = addr_s;
               if (col_d != ColsFull) short_d = 1'b1;
               col_d   = '0;
               drain_d = '0;
               state_d = StDrainTop;
            end
         end
         StDrainTop: begin
            if (hlat_rise) overrun_d = 1'b1;
            drain_d = drain_q + 1'b1;
            if (drain_q == LastIdx) state_d = StDrainBot;
         end
         StDrainBot: begin
            if (hlat_rise) overrun_d = 1'b1;
            drain_d = drain_q + 1'b1;
            if (drain_q == LastIdx) begin
               state_d      = StShift;
               line_done_d  = 1'b1;
               frame_done_d = (row_q == LastRow);
            end
         end
         default: state_d = StShift;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StShift;
         col_q        <= '0;
         drain_q      <= '0;
         row_q        <= '0;
         short_q      <= 1'b0;
         overrun_q    <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         drain_q      <= drain_d;
         row_q        <= row_d;
         short_q      <= short_d;
         overrun_q    <= overrun_d;
         line_done_q  <= line_done_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we) line_buf[col_q[COL_W-1:0]] <= '{rgb0: rgb0_s, rgb1: rgb1_s};
   end

   // Outputs decode from the state register so an async reset drops wr_en at once.
   assign rd_ent      = line_buf[drain_q];
   assign wr_en       = (state_q != StShift);
   assign wr_addr     = wr_en ? {(state_q == StDrainBot), row_q, drain_q} : '0;
   assign wr_data     = !wr_en ? 3'b000 : (state_q == StDrainBot) ? rd_ent.rgb1 : rd_ent.rgb0;
   assign line_done   = line_done_q;
   assign frame_done  = frame_done_q;
   assign err_short   = short_q;
   assign err_overrun = overrun_q;

`ifdef HUB75_OE_CHECK_EN
   logic [ROW_W-1:0] addr_prev_q;
   logic             oe_prev_q, err_oe_q;
   logic             unused_sigs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_prev_q <= '0;
         oe_prev_q   <= 1'b1;
         err_oe_q    <= 1'b0;
      end else begin
         addr_prev_q <= addr_s;
         oe_prev_q   <= oe_s;
         if (!oe_s && (hlat_rise || (!oe_prev_q && addr_s != addr_prev_q))) err_oe_q <= 1'b1;
      end
   end

   assign err_oe      = err_oe_q;
   assign unused_sigs = ^{hclk_q, hlat_q, data_rise};
`else
   logic unused_sigs;
   assign unused_sigs = ^{hclk_q, hlat_q, data_rise, oe_s};
`endif

endmodule

// File: tb/tb_hub75_capture_rx.sv
// Scoreboard bench for hub75_capture_rx: a line-buffer model predicts every frame-store write.
module tb_hub75_capture_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1;
   logic [2:0]  hub_rgb0 = '0, hub_rgb1 = '0;
   logic [4:0]  hub_addr = '0;
   logic        wr_en, line_done, frame_done, err_short, err_overrun;
   logic [11:0] wr_addr;
   logic [2:0]  wr_data;
`ifdef HUB75_OE_CHECK_EN
   logic        err_oe;
`endif

   always #5 clk = ~clk;

   hub75_capture_rx dut (
      .clk         (clk),
      .rst         (rst),
      .hub_clk     (hub_clk),
      .hub_lat     (hub_lat),
      .hub_oe      (hub_oe),
      .hub_rgb0    (hub_rgb0),
      .hub_rgb1    (hub_rgb1),
      .hub_addr    (hub_addr),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .line_done   (line_done),
      .frame_done  (frame_done),
      .err_short   (err_short),
`ifdef HUB75_OE_CHECK_EN
      .err_oe      (err_oe),
`endif
      .err_overrun (err_overrun)
   );

   typedef struct {
      logic [11:0] addr;
      logic [2:0]  data;
   } exp_t;

   exp_t       exp_q[$];
   int         n_vec = 0, n_err = 0;
   int         wr_cnt = 0, line_cnt = 0, frame_cnt = 0, frame_line = 0;
   logic [2:0] fs [4096];
   logic [2:0] lb_top [64];
   logic [2:0] lb_bot [64];
   int         tb_col = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         fs[wr_addr] = wr_data;
         if (exp_q.size() == 0) begin
            check("extra_wr", 32'(wr_addr), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
         end
      end
      if (line_done) line_cnt++;
      if (frame_done) begin
         frame_cnt++;
         frame_line = line_cnt;
         check("frame_with_line", 32'(line_done), 32'd1);
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [2:0] cb(input int r, input int c);
      return (((r ^ c) & 1) != 0) ? 3'b110 : 3'b001;
   endfunction

   task automatic shift_px(input logic [2:0] top, input logic [2:0] bot);
      hub_rgb0 = top;
      hub_rgb1 = bot;
      if (tb_col < 64) begin
         lb_top[tb_col] = top;
         lb_bot[tb_col] = bot;
         tb_col++;
      end
      wait_clks(3);
      hub_clk = 1'b1;
      wait_clks(3);
      hub_clk = 1'b0;
   endtask

   task automatic latch(input logic [4:0] a);
      for (int i = 0; i < 64; i++) begin
         logic [5:0] c;
         c = 6'(i);
         exp_q.push_back('{addr: {1'b0, a, c}, data: lb_top[i]});
      end
      for (int i = 0; i < 64; i++) begin
         logic [5:0] c;
         c = 6'(i);
         exp_q.push_back('{addr: {1'b1, a, c}, data: lb_bot[i]});
      end
      tb_col   = 0;
      hub_addr = a;
      wait_clks(1);
      hub_lat = 1'b1;
      wait_clks(3);
      hub_lat = 1'b0;
      wait_clks(1);
   endtask

   task automatic wait_line();
      int base;
      base = line_cnt;
      for (int i = 0; i < 400 && line_cnt == base; i++) @(negedge clk);
      check("line_done_seen", 32'(line_cnt - base), 32'd1);
      wait_clks(2);
      check("exp_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      tb_col = 0;
      exp_q.delete();
      wait_clks(3);
   endtask

   initial begin
      int wb, lb, fb;
      wait_clks(3);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_line_done", 32'(line_done), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_err_short", 32'(err_short), 0);
      check("rst_err_overrun", 32'(err_overrun), 0);
      rst = 1'b0;
      wait_clks(3);

      // Single line, row 5.
      wb = wr_cnt; lb = line_cnt; fb = frame_cnt;
      for (int i = 0; i < 64; i++) shift_px(3'(i), ~3'(i));
      latch(5'd5);
      wait_line();
      check("line1_writes", 32'(wr_cnt - wb), 128);
      check("line1_line_done", 32'(line_cnt - lb), 1);
      check("line1_no_frame", 32'(frame_cnt - fb), 0);
      check("line1_err_short", 32'(err_short), 0);
      check("line1_err_overrun", 32'(err_overrun), 0);

      // Full checkerboard frame.
      lb = line_cnt; fb = frame_cnt;
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 64; c++) shift_px(cb(r, c), cb(r + 32, c));
         latch(5'(r));
         wait_line();
      end
      check("frame_done_cnt", 32'(frame_cnt - fb), 1);
      check("frame_done_after_row31", 32'(frame_line - lb), 32);
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++) begin
            logic [11:0] fa;
            fa = {6'(r), 6'(c)};
            check("frame_store", 32'(fs[fa]), 32'(cb(r, c)));
         end

      // Short line: column 63 keeps stale data.
      wb = wr_cnt;
      for (int i = 0; i < 63; i++) shift_px(3'(i + 3), 3'(i + 5));
      latch(5'd7);
      wait_line();
      check("short_err_short", 32'(err_short), 1);
      check("short_writes", 32'(wr_cnt - wb), 128);
      check("short_err_overrun", 32'(err_overrun), 0);

      // Reset during write 40 of the top drain.
      for (int i = 0; i < 64; i++) shift_px(3'(i), 3'(i + 1));
      wb = wr_cnt;
      latch(5'd12);
      for (int i = 0; i < 300 && (wr_cnt - wb) < 39; i++) @(posedge clk);
      check("pre_rst_writes", 32'(wr_cnt - wb), 39);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_wr_en", 32'(wr_en), 0);
      check("rst_mid_wr_addr", 32'(wr_addr), 0);
      exp_q.delete();
      wait_clks(3);
      rst = 1'b0;
      tb_col = 0;
      wait_clks(3);
      check("post_rst_err_short", 32'(err_short), 0);
      wb = wr_cnt;
      for (int i = 0; i < 64; i++) shift_px(3'(i * 3), 3'(i * 5));
      latch(5'd13);
      wait_line();
      check("fresh_writes", 32'(wr_cnt - wb), 128);

      // 65 shifts: the extra pixel is discarded.
      wb = wr_cnt;
      for (int i = 0; i < 65; i++) shift_px(3'(i + 1), 3'(i + 2));
      latch(5'd9);
      wait_line();
      check("ovr_err_overrun", 32'(err_overrun), 1);
      check("ovr_err_short", 32'(err_short), 0);
      check("ovr_col0_top", 32'(fs[12'h240]), 32'd1);
      check("ovr_writes", 32'(wr_cnt - wb), 128);

      // Latch reissued during a drain is ignored.
      do_reset();
      check("pre_reissue_overrun", 32'(err_overrun), 0);
      for (int i = 0; i < 64; i++) shift_px(3'(i + 4), 3'(i + 6));
      wb = wr_cnt;
      latch(5'd17);
      for (int i = 0; i < 300 && (wr_cnt - wb) < 10; i++) @(negedge clk);
      hub_addr = 5'd20;
      hub_lat  = 1'b1;
      wait_clks(3);
      hub_lat  = 1'b0;
      wait_line();
      check("reissue_overrun", 32'(err_overrun), 1);
      check("reissue_writes", 32'(wr_cnt - wb), 128);
      wait_clks(20);
      check("reissue_no_extra", 32'(wr_cnt - wb), 128);

`ifdef HUB75_OE_CHECK_EN
      do_reset();
      check("oe_clear", 32'(err_oe), 0);
      for (int i = 0; i < 64; i++) shift_px(3'(i), 3'(i));
      hub_oe = 1'b0;
      latch(5'd2);
      wait_line();
      check("oe_err_set", 32'(err_oe), 1);
      hub_oe = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
